genesis_pad_scanner: RTL

- Multi-pad Sega-style controller front end. Scans NUM_PADS 3/6-button pads on one shared select line, detects the pad type, and debounces all 12 buttons.
- Produces per-button level outputs, press pulses, and d-pad auto-repeat pulses for the game logic and menu FSMs.
- Replaces the fixed single-pad reader/handler pair.

---
 rtl/genesis_pad_scanner.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/genesis_pad_scanner.sv
// genesis_pad_scanner: scans Sega-style 3/6-button pads on a shared select line, debounces buttons, makes press and d-pad repeat pulses
module genesis_pad_scanner #(
    parameter int NUM_PADS        = 2,
    parameter int SEL_HALF_CYCLES = 1000,
    parameter int IDLE_CYCLES     = 20000,
    parameter int DEBOUNCE_SCANS  = 3,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6*NUM_PADS-1:0]  pad_pins,
    input  logic                   block_controller,
    output logic                   select,
    output logic [12*NUM_PADS-1:0] buttons,
    output logic [12*NUM_PADS-1:0] press_pulse,
    output logic [NUM_PADS-1:0]    pad_present,
    output logic [NUM_PADS-1:0]    six_button,
    output logic                   scan_done
);
    localparam int CMAX = (IDLE_CYCLES > SEL_HALF_CYCLES) ? IDLE_CYCLES : SEL_HALF_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] SEL_LAST = CW'(SEL_HALF_CYCLES - 1);
    localparam logic [SW-1:0] DEB_FULL = SW'(DEBOUNCE_SCANS);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_WRAP = RW'(REPEAT_DELAY + REPEAT_RATE - 1);
    // X, Y, Z and mode only exist on a six-button pad
    localparam logic [11:0] EXT_MASK = 12'h01D;

    typedef enum logic [1:0] {IDLE, PHASE, UPDATE} state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [2:0]             phase_q;
    logic [2:0]             phase_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   select_q;
    logic                   select_d;
    logic                   scan_done_q;
    logic                   scan_done_d;
    logic                   phase_end;
    logic                   upd;

    logic [11:0]            raw_q [NUM_PADS];
    logic [11:0]            raw_d [NUM_PADS];
    logic [11:0]            prev_q [NUM_PADS];
    logic [11:0]            prev_d [NUM_PADS];
    logic [SW-1:0]          stable_q [NUM_PADS];
    logic [SW-1:0]          stable_d [NUM_PADS];
    logic [RW-1:0]          rep_q [NUM_PADS];
    logic [RW-1:0]          rep_d [NUM_PADS];
    logic [5:0]             inv [NUM_PADS];
    logic [11:0]            snap [NUM_PADS];
    logic [11:0]            btn_old [NUM_PADS];
    logic [11:0]            btn_new [NUM_PADS];
    logic [NUM_PADS-1:0]    rep_hit;
    logic [NUM_PADS-1:0]    det_present_q;
    logic [NUM_PADS-1:0]    det_present_d;
    logic [NUM_PADS-1:0]    det_six_q;
    logic [NUM_PADS-1:0]    det_six_d;
    logic [NUM_PADS-1:0]    pad_present_q;
    logic [NUM_PADS-1:0]    pad_present_d;
    logic [NUM_PADS-1:0]    six_button_q;
    logic [NUM_PADS-1:0]    six_button_d;
    logic [12*NUM_PADS-1:0] buttons_q;
    logic [12*NUM_PADS-1:0] buttons_d;
    logic [12*NUM_PADS-1:0] pulse_q;
    logic [12*NUM_PADS-1:0] pulse_d;

    // last cycle of a select phase is the only point where pins are sampled
    assign phase_end = (state_q == PHASE) && (cnt_q == SEL_LAST);
    // results are committed on the edge that enters UPDATE so they are visible with scan_done
    assign upd = phase_end && (phase_q == 3'd7);

    // scan sequencer next state; select and scan_done are derived from the next state so they come straight from flops
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = PHASE;
                    phase_d = 3'd0;
                    cnt_d = '0;
                end
            end
            PHASE: begin
                if (phase_end) begin
                    cnt_d = '0;
                    state_d = (phase_q == 3'd7) ? UPDATE : PHASE;
                    phase_d = phase_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d = '0;
            end
        endcase
        select_d = (state_d == PHASE) ? ~phase_d[0] : 1'b1;
        scan_done_d = state_d == UPDATE;
    end

    // per-pad sampling, snapshot masking, debounce, edge and auto-repeat pulse generation
    always_comb begin
        det_present_d = det_present_q;
        det_six_d = det_six_q;
        pad_present_d = upd ? det_present_q : pad_present_q;
        six_button_d = upd ? det_six_q : six_button_q;
        buttons_d = buttons_q;
        pulse_d = '0;
        rep_hit = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            inv[p] = ~pad_pins[6*p +: 6];
            raw_d[p] = raw_q[p];
            prev_d[p] = prev_q[p];
            stable_d[p] = stable_q[p];
            rep_d[p] = rep_q[p];
            snap[p] = det_present_q[p] ? (det_six_q[p] ? raw_q[p] : raw_q[p] & ~EXT_MASK) : 12'h000;
            btn_old[p] = buttons_q[12*p +: 12];
            btn_new[p] = btn_old[p];
            if (phase_end) begin
                if (phase_q == 3'd0) begin
                    raw_d[p][11:8] = inv[p][5:2];
                    raw_d[p][6:5] = inv[p][1:0];
                end
                if (phase_q == 3'd1) begin
                    raw_d[p][7] = inv[p][1];
                    raw_d[p][1] = inv[p][0];
                    det_present_d[p] = &inv[p][3:2];
                end
                if (phase_q == 3'd5) det_six_d[p] = &inv[p][5:2];
                if (phase_q == 3'd6) begin
                    raw_d[p][4:2] = {inv[p][3], inv[p][4], inv[p][5]};
                    raw_d[p][0] = inv[p][2];
                end
            end
            if (upd) begin
                stable_d[p] = (snap[p] != prev_q[p]) ? SW'(1) : ((stable_q[p] == DEB_FULL) ? DEB_FULL : stable_q[p] + 1'b1);
                prev_d[p] = snap[p];
                btn_new[p] = (stable_d[p] == DEB_FULL) ? snap[p] : btn_old[p];
                // the repeat counter wraps from the last slot of a period back to the first-repeat value
                rep_d[p] = (btn_new[p][11:8] != btn_old[p][11:8] || btn_new[p][11:8] == 4'h0) ? '0 :
                           ((rep_q[p] == REP_WRAP) ? REP_FIRST : rep_q[p] + 1'b1);
                rep_hit[p] = (rep_d[p] == REP_FIRST) && (btn_new[p][11:8] != 4'h0);
                buttons_d[12*p +: 12] = btn_new[p];
                pulse_d[12*p +: 12] = block_controller ? 12'h000 :
                                      (btn_new[p] & ~btn_old[p]) | {rep_hit[p] ? btn_new[p][11:8] : 4'h0, 8'h00};
            end
        end
    end

    // scan sequencer state and registered select / scan_done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= 3'd0;
            cnt_q <= '0;
            select_q <= 1'b1;
            scan_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q <= cnt_d;
            select_q <= select_d;
            scan_done_q <= scan_done_d;
        end
    end

    // per-pad capture, debounce history, repeat counters and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                raw_q[p] <= '0;
                prev_q[p] <= '0;
                stable_q[p] <= '0;
                rep_q[p] <= '0;
            end
            det_present_q <= '0;
            det_six_q <= '0;
            pad_present_q <= '0;
            six_button_q <= '0;
            buttons_q <= '0;
            pulse_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
                raw_q[p] <= raw_d[p];
                prev_q[p] <= prev_d[p];
                stable_q[p] <= stable_d[p];
                rep_q[p] <= rep_d[p];
            end
            det_present_q <= det_present_d;
            det_six_q <= det_six_d;
            pad_present_q <= pad_present_d;
            six_button_q <= six_button_d;
            buttons_q <= buttons_d;
            pulse_q <= pulse_d;
        end
    end

    assign select = select_q;
    assign scan_done = scan_done_q;
    assign buttons = buttons_q;
    assign press_pulse = pulse_q;
    assign pad_present = pad_present_q;
    assign six_button = six_button_q;

endmodule
